// File: rtl/w0rm_core_pkg.sv
// w0rm_core_pkg: redirect FSM state encodings and FLUSH_CYCLES legal range
package w0rm_core_pkg;
  typedef enum logic [1:0] {
    RDR_IDLE     = 2'd0,
    RDR_FLUSH    = 2'd1,
    RDR_REDIRECT = 2'd2
  } rdr_state_e;
  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 15;
endpackage

// File: rtl/w0rm_redirect_arb.sv
// w0rm_redirect_arb: redirect source select, branch wins over interrupt
module w0rm_redirect_arb #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  br_pc_valid,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic                  irq_req,
  input  logic [ADDR_WIDTH-1:0] irq_vector,
  output logic                  take,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  is_irq
);
  always_comb begin
    take   = br_pc_valid | irq_req;
    is_irq = !br_pc_valid && irq_req;
    target = br_pc_valid ? br_pc : irq_vector;
  end
endmodule

// File: rtl/w0rm_core_redirect_ctrl.sv
// w0rm_core_redirect_ctrl: flush/stall sequencing and fetch redirect handshake
// Optional interrupt redirects are enabled by defining W0RM_REDIRECT_IRQ_EN.
module w0rm_core_redirect_ctrl
  import w0rm_core_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_pc_valid,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic                  irq_req,
  input  logic [ADDR_WIDTH-1:0] irq_vector,
  output logic                  irq_ack,
  output logic                  flush_pipeline,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_pc_valid,
  input  logic                  fetch_ready,
  output logic [CNT_WIDTH-1:0]  redirect_count
);
  if (FLUSH_CYCLES < FLUSH_CYCLES_MIN || FLUSH_CYCLES > FLUSH_CYCLES_MAX) begin : g_bad_flush
    $error("FLUSH_CYCLES must be within 1..15");
  end
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  rdr_state_e            state;
  logic [3:0]            flush_cnt;
  logic [ADDR_WIDTH-1:0] target_r;
  logic [ADDR_WIDTH-1:0] src_pc;
  logic                  take;
`ifdef W0RM_REDIRECT_IRQ_EN
  logic is_irq;
  w0rm_redirect_arb #(.ADDR_WIDTH(ADDR_WIDTH)) u_arb (
    .br_pc_valid(br_pc_valid),
    .br_pc      (br_pc),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .take       (take),
    .target     (src_pc),
    .is_irq     (is_irq)
  );
`else
  logic unused_irq;
  assign take       = br_pc_valid;
  assign src_pc     = br_pc;
  assign irq_ack    = 1'b0;
  assign unused_irq = ^{irq_req, irq_vector};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RDR_IDLE;
      flush_cnt      <= '0;
      target_r       <= '0;
      flush_pipeline <= 1'b0;
      stall          <= 1'b0;
      fetch_pc       <= '0;
      fetch_pc_valid <= 1'b0;
      redirect_count <= '0;
`ifdef W0RM_REDIRECT_IRQ_EN
      irq_ack        <= 1'b0;
`endif
    end else begin
`ifdef W0RM_REDIRECT_IRQ_EN
      irq_ack <= 1'b0;
`endif
      case (state)
        RDR_IDLE: if (take) begin
          state          <= RDR_FLUSH;
          target_r       <= src_pc;
          flush_cnt      <= FLUSH_LOAD;
          flush_pipeline <= 1'b1;
          stall          <= 1'b1;
`ifdef W0RM_REDIRECT_IRQ_EN
          irq_ack        <= is_irq;
`endif
        end
        RDR_FLUSH: if (flush_cnt == '0) begin
          state          <= RDR_REDIRECT;
          flush_pipeline <= 1'b0;
          fetch_pc       <= target_r;
          fetch_pc_valid <= 1'b1;
        end else begin
          flush_cnt <= flush_cnt - 4'd1;
        end
        RDR_REDIRECT: if (fetch_ready) begin
          state          <= RDR_IDLE;
          fetch_pc_valid <= 1'b0;
          stall          <= 1'b0;
          redirect_count <= redirect_count + CNT_WIDTH'(1);
        end
        default: state <= RDR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_w0rm_core_redirect_ctrl.sv
// tb_w0rm_core_redirect_ctrl: scoreboard bench for the redirect controller
module tb_w0rm_core_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_pc_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic        irq_req = 1'b0;
  logic [31:0] irq_vector = '0;
  logic        irq_ack;
  logic        flush_pipeline;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        fetch_pc_valid;
  logic        fetch_ready = 1'b0;
  logic [3:0]  redirect_count;
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  w0rm_core_redirect_ctrl #(.ADDR_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .br_pc_valid(br_pc_valid), .br_pc(br_pc),
    .irq_req(irq_req), .irq_vector(irq_vector), .irq_ack(irq_ack),
    .flush_pipeline(flush_pipeline), .stall(stall), .fetch_pc(fetch_pc),
    .fetch_pc_valid(fetch_pc_valid), .fetch_ready(fetch_ready),
    .redirect_count(redirect_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic f, input logic s, input logic v);
    @(negedge clk);
    chk({tag, "_flush"}, 32'(flush_pipeline), 32'(f));
    chk({tag, "_stall"}, 32'(stall), 32'(s));
    chk({tag, "_valid"}, 32'(fetch_pc_valid), 32'(v));
    tick();
  endtask
  task automatic branch(input logic [31:0] a);
    br_pc_valid = 1'b1;
    br_pc = a;
    q.push_back(a);
    tick();
    br_pc_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    for (int k = 0; k < 60 && q.size() != 0; k++) tick();
    chk({tag, "_drain"}, 32'(q.size()), 0);
    chk({tag, "_stall_idle"}, 32'(stall), 0);
    chk({tag, "_count"}, 32'(redirect_count), 32'(exp_cnt[3:0]));
  endtask
  // every accepted redirect must match the oldest queued target
  always @(negedge clk) begin
    if (rst_n && fetch_pc_valid && fetch_ready) begin
      if (q.size() == 0) chk("unexpected_redirect", fetch_pc, 32'hFFFF_FFFF);
      else chk("fetch_pc", fetch_pc, q.pop_front());
      exp_cnt++;
    end
  end
  initial begin
    #1;
    chk("rst_valid", 32'(fetch_pc_valid), 0);
    chk("rst_count", 32'(redirect_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_ready = 1'b1;
    branch(32'h100);
    chk_out("t2_c1", 1, 1, 0);
    chk_out("t2_c2", 1, 1, 0);
    @(negedge clk);
    chk("t2_pc", fetch_pc, 32'h100);
    tick();
    chk_out("t2_c4", 0, 0, 0);
    chk("t2_count", 32'(redirect_count), 1);
    fetch_ready = 1'b0;
    branch(32'h300);
    chk_out("t3_c1", 1, 1, 0);
    chk_out("t3_c2", 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(fetch_pc_valid), 1);
      chk("t3_hold_pc", fetch_pc, 32'h300);
      tick();
    end
    fetch_ready = 1'b1;
    drain("t3");
    branch(32'h100);
    br_pc_valid = 1'b1;
    br_pc = 32'h200;
    tick();
    br_pc_valid = 1'b0;
    drain("t4");
    for (int i = 0; i < 4; i++) chk_out("t4_quiet", 0, 0, 0);
    branch(32'h700);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_flush", 32'(flush_pipeline), 0);
    chk("t1_stall", 32'(stall), 0);
    chk("t1_valid", 32'(fetch_pc_valid), 0);
    chk("t1_pc", fetch_pc, 0);
    chk("t1_count", 32'(redirect_count), 0);
    chk("t1_ack", 32'(irq_ack), 0);
    q.delete();
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) chk_out("t1_idle", 0, 0, 0);
`ifdef W0RM_REDIRECT_IRQ_EN
    begin
      int n_ack = 0;
      int ack_at = 0;
      irq_req = 1'b1;
      irq_vector = 32'h40;
      q.push_back(32'h500);
      q.push_back(32'h40);
      br_pc_valid = 1'b1;
      br_pc = 32'h500;
      tick();
      br_pc_valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        if (irq_ack) begin
          n_ack++;
          ack_at = i;
          irq_req = 1'b0;
        end
        tick();
      end
      chk("t5_ack_n", 32'(n_ack), 1);
      chk("t5_ack_at", 32'(ack_at), 5);
      drain("t5");
    end
`endif
    for (int i = 0; i < 15; i++) begin
      branch(32'h1000 + 32'(i * 4));
      drain("t6_step");
    end
    chk("t6_count15", 32'(redirect_count), 32'(4'd15 + 4'(exp_cnt - 15)));
    branch(32'h2000);
    drain("t6_wrap");
    chk("t6_wrapval", 32'(redirect_count), 32'(4'(exp_cnt)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
